// File: rtl/ahb_master_if_pkg.sv
// rtl/ahb_master_if_pkg.sv - shared AHB codes and state encodings for the slave-port output stage
//
// Purpose: HTRANS/HRESP encodings, FSM state type and hold-counter width
//          used by ahb_master_if and its arbiter.
// Ports:   none (package).

package ahb_master_if_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ERR2  = 2'd2
  } state_e;

  // NONSEQ and SEQ are the only codes with bit 1 set: both carry a real beat.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_master_if_rr_arbiter.sv
// rtl/ahb_master_if_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request scanning upward from ptr,
//          wrapping at NUM_PORTS; no grant when en is low.
// Ports:   req      in  NUM_PORTS  requests
//          en       in  1          arbitration allowed this cycle
//          ptr      in  PTR_W      index where the scan starts
//          gnt      out NUM_PORTS  one-hot winner
//          gnt_idx  out PTR_W      index of the winner
//          gnt_vld  out 1          a winner exists

module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

  localparam logic [PTR_W:0] NUM_PORTS_W = (PTR_W+1)'(NUM_PORTS);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    idx     = '0;
    if (en) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        sum = {1'b0, ptr} + (PTR_W+1)'(i);
        if (sum >= NUM_PORTS_W) begin
          sum = sum - NUM_PORTS_W;
        end
        idx = sum[PTR_W-1:0];
        if (!gnt_vld && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          gnt_vld  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_master_if.sv
// rtl/ahb_master_if.sv - bus-matrix output stage driving one AHB slave port
//
// Purpose: round-robin arbitration among slave interfaces targeting this
//          slave, address/control mux by gnt, write-data mux by data_gnt,
//          slave response returned to the data-phase owner.
// Ports:   hclk, hresetn                 clock, synchronous active-low reset
//          req, *_all                    per-requester request and AHB signals
//          gnt, data_gnt                 registered one-hot address/data owners
//          m_hsel .. m_hready            AHB address/control/data to slave
//          m_hreadyout, m_hresp, m_hrdata  slave response
//          s_hready, s_hresp, s_hrdata   response back to slave interfaces

module ahb_master_if
  import ahb_master_if_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8
) (
  input  logic                            hclk,
  input  logic                            hresetn,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] haddr_all,
  input  logic [NUM_PORTS*2-1:0]          htrans_all,
  input  logic [NUM_PORTS-1:0]            hwrite_all,
  input  logic [NUM_PORTS*3-1:0]          hsize_all,
  input  logic [NUM_PORTS*3-1:0]          hburst_all,
  input  logic [NUM_PORTS*4-1:0]          hprot_all,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] hwdata_all,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            data_gnt,
  output logic                            m_hsel,
  output logic [ADDR_WIDTH-1:0]           m_haddr,
  output logic [1:0]                      m_htrans,
  output logic                            m_hwrite,
  output logic [2:0]                      m_hsize,
  output logic [2:0]                      m_hburst,
  output logic [3:0]                      m_hprot,
  output logic [DATA_WIDTH-1:0]           m_hwdata,
  output logic                            m_hready,
  input  logic                            m_hreadyout,
  input  logic [1:0]                      m_hresp,
  input  logic [DATA_WIDTH-1:0]           m_hrdata,
  output logic                            s_hready,
  output logic [1:0]                      s_hresp,
  output logic [DATA_WIDTH-1:0]           s_hrdata
);

  localparam int              PTR_W      = $clog2(NUM_PORTS);
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_PORTS - 1);

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  data_gnt_q, data_gnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;

  logic [NUM_PORTS-1:0]  arb_req;
  logic                  arb_en;
  logic [NUM_PORTS-1:0]  arb_gnt;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic [PTR_W-1:0]      ptr_next;

  logic                  owner_vld;
  logic                  own_req;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [1:0]            own_htrans;
  logic                  own_hwrite;
  logic [2:0]            own_hsize;
  logic [2:0]            own_hburst;
  logic [3:0]            own_hprot;
  logic [DATA_WIDTH-1:0] dat_hwdata;

  logic                  err_first;
  logic                  beat;
  logic [HOLD_W-1:0]     hold_inc;
  logic                  can_preempt;

  // The current owner never competes against itself: when it drops req it is
  // already excluded, and when pre-empted the grant must move elsewhere.
  assign arb_req  = req & ~gnt_q;
  assign arb_en   = m_hreadyout && (state_q != ST_ERR2);
  assign ptr_next = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req     (arb_req),
    .en      (arb_en),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Address/control mux by gnt and write-data mux by data_gnt; both one-hot,
  // so OR-ing the selected slices gives zero when nobody is selected.
  always_comb begin
    own_addr   = '0;
    own_htrans = HTRANS_IDLE;
    own_hwrite = 1'b0;
    own_hsize  = '0;
    own_hburst = '0;
    own_hprot  = '0;
    dat_hwdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_q[i]) begin
        own_addr   = own_addr   | haddr_all[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_htrans = own_htrans | htrans_all[i*2 +: 2];
        own_hwrite = own_hwrite | hwrite_all[i];
        own_hsize  = own_hsize  | hsize_all[i*3 +: 3];
        own_hburst = own_hburst | hburst_all[i*3 +: 3];
        own_hprot  = own_hprot  | hprot_all[i*4 +: 4];
      end
      if (data_gnt_q[i]) begin
        dat_hwdata = dat_hwdata | hwdata_all[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_vld = |gnt_q;
  assign own_req   = |(req & gnt_q);

  // First cycle of a two-cycle ERROR/RETRY/SPLIT: the slave is stalling with a
  // non-OKAY response, so the pending address phase must be cancelled.
  assign err_first = (m_hresp != HRESP_OKAY) && !m_hreadyout;

  assign m_hsel   = owner_vld;
  assign m_htrans = (owner_vld && !err_first) ? own_htrans : HTRANS_IDLE;
  assign m_haddr  = own_addr;
  assign m_hwrite = own_hwrite;
  assign m_hsize  = own_hsize;
  assign m_hburst = own_hburst;
  assign m_hprot  = own_hprot;
  assign m_hwdata = dat_hwdata;
  assign m_hready = m_hreadyout;

  assign s_hready = (|data_gnt_q) ? m_hreadyout : 1'b1;
  assign s_hresp  = (|data_gnt_q) ? m_hresp     : HRESP_OKAY;
  assign s_hrdata = (|data_gnt_q) ? m_hrdata    : '0;

  assign gnt      = gnt_q;
  assign data_gnt = data_gnt_q;

  // The hold limit is judged on the count including the beat accepted on this
  // edge, so an owner keeps the bus for exactly MAX_HOLD beats before it can be
  // pre-empted. Pre-emption only lands on a burst boundary (IDLE or NONSEQ).
  assign beat        = m_hreadyout && trans_active(m_htrans);
  assign hold_inc    = (beat && (hold_q != '1)) ? hold_q + 1'b1 : hold_q;
  assign can_preempt = (hold_inc >= MAX_HOLD_C) &&
                       ((own_htrans == HTRANS_IDLE) || (own_htrans == HTRANS_NONSEQ));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    data_gnt_d = data_gnt_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;

    if (m_hreadyout) begin
      data_gnt_d = trans_active(m_htrans) ? gnt_q : '0;
      hold_d     = hold_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (err_first) begin
          state_d = ST_ERR2;
        end else if (arb_vld) begin
          gnt_d   = arb_gnt;
          ptr_d   = ptr_next;
          hold_d  = '0;
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (err_first) begin
          state_d = ST_ERR2;
        end else if (m_hreadyout) begin
          if (!own_req) begin
            if (arb_vld) begin
              gnt_d  = arb_gnt;
              ptr_d  = ptr_next;
              hold_d = '0;
            end else begin
              gnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else if (can_preempt && arb_vld) begin
            gnt_d  = arb_gnt;
            ptr_d  = ptr_next;
            hold_d = '0;
          end
        end
      end
      ST_ERR2: begin
        // The grant rides through an error untouched.
        if (m_hreadyout) begin
          state_d = owner_vld ? ST_OWNED : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      data_gnt_q <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      data_gnt_q <= data_gnt_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
    end
  end

endmodule
